copy_dma: RTL and testbench

Parametrised, start-triggered successor to the sentinel copy engine: copies words from a source memory region to a destination region through external synchronous memory ports. Terminates on sentinel or programmed length, source end, destination full, parity error or abort. Reports a held status code and counters. Sits between the control/register block and two single-port RAMs (source read-only, destination write-only).

---
 rtl/copy_pkg.sv | 24 ++
 rtl/copy_ptr.sv | 52 +++++
 rtl/copy_dma.sv | 180 ++++++++++++++++++
 tb/tb_copy_dma.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/copy_pkg.sv
// Shared types and constants for the copy DMA engine.
package copy_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_CHK  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Termination status codes reported on the status output.
   localparam logic [2:0] ST_NONE    = 3'd0;
   localparam logic [2:0] ST_SENT    = 3'd1;
   localparam logic [2:0] ST_LEN     = 3'd2;
   localparam logic [2:0] ST_SRC_END = 3'd3;
   localparam logic [2:0] ST_FULL    = 3'd4;
   localparam logic [2:0] ST_ERR     = 3'd5;
   localparam logic [2:0] ST_ABORT   = 3'd6;

   // Run modes.
   localparam logic MODE_SENT = 1'b0;
   localparam logic MODE_LEN  = 1'b1;

endpackage

// File: rtl/copy_ptr.sv
// Loadable address pointer that refuses to wrap: incrementing from the last
// address leaves the pointer there and raises a sticky exhausted flag.
module copy_ptr #(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_val,
   input  logic              inc,
   output logic [ADDR_W-1:0] ptr,
   output logic              at_last,
   output logic              exhausted
);

   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              exh_q, exh_d;

   // Next pointer: load wins over increment; increment at the top saturates.
   always_comb begin
      // NOTE: defaults first so every path assigns every output -- no latch.
      ptr_d = ptr_q;
      exh_d = exh_q;
      if (load) begin
         ptr_d = load_val;
         exh_d = 1'b0;
      end else if (inc) begin
         if (ptr_q == '1) begin
            exh_d = 1'b1;
         end else begin
            ptr_d = ptr_q + ADDR_W'(1);
         end
      end
   end

   // Pointer and exhausted flag registers.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: non-blocking assignments for state so all flops update together.
      if (!rst) begin
         ptr_q <= '0;
         exh_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
         exh_q <= exh_d;
      end
   end

   assign ptr       = ptr_q;
   assign at_last   = (ptr_q == '1);
   assign exhausted = exh_q;

endmodule

// File: rtl/copy_dma.sv
// Start-triggered word copy engine: reads a source RAM, writes a destination
// RAM, terminates on sentinel/length/source end/destination full/parity/abort.
module copy_dma
   import copy_pkg::*;
#(
   parameter int               ADDR_W   = 12,
   parameter int               WIDTH    = 16,
   parameter logic [WIDTH-1:0] SENTINEL = '1,
   parameter int               ERR_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic              mode,
   input  logic              stop_on_err,
   input  logic [ADDR_W-1:0] src_start,
   input  logic [ADDR_W-1:0] dst_start,
   input  logic [ADDR_W:0]   len,
   output logic              src_rd_en,
   output logic [ADDR_W-1:0] src_addr,
   input  logic [WIDTH-1:0]  src_rd_data,
   input  logic              src_rd_par,
   output logic              dst_wr_en,
   output logic [ADDR_W-1:0] dst_addr,
   output logic [WIDTH-1:0]  dst_wr_data,
   output logic              busy,
   output logic              done,
   output logic [2:0]        status,
   output logic [ADDR_W:0]   word_cnt,
   output logic [ERR_W-1:0]  err_cnt
);

   state_t            state_q, state_d;
   logic              mode_q, mode_d;
   logic              soe_q, soe_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [2:0]        status_q, status_d;
   logic [ADDR_W:0]   wc_q, wc_d;
   logic [ERR_W-1:0]  ec_q, ec_d;

   logic              ptr_load, src_inc, dst_inc;
   logic [ADDR_W-1:0] src_ptr, dst_ptr;
   logic              src_at_last, src_exh, dst_at_last, dst_exh;
   logic              par_err, cont;
   logic [ERR_W-1:0]  ec_inc;

   copy_ptr #(.ADDR_W(ADDR_W)) u_src_ptr (
      .clk(clk), .rst(rst), .load(ptr_load), .load_val(src_start), .inc(src_inc),
      .ptr(src_ptr), .at_last(src_at_last), .exhausted(src_exh)
   );

   copy_ptr #(.ADDR_W(ADDR_W)) u_dst_ptr (
      .clk(clk), .rst(rst), .load(ptr_load), .load_val(dst_start), .inc(dst_inc),
      .ptr(dst_ptr), .at_last(dst_at_last), .exhausted(dst_exh)
   );

   // The source never steps past its last address and the destination stops on
   // its exhausted flag, so these two pointer flags have no consumer here.
   logic unused_ptr_flags;
   assign unused_ptr_flags = src_exh ^ dst_at_last;

   // Even parity over data plus parity bit; any odd count is an error.
   assign par_err = ^{src_rd_data, src_rd_par};
   assign ec_inc  = (ec_q == '1) ? ec_q : ec_q + ERR_W'(1);

   // Next-state, counters and memory strobes.
   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      soe_d     = soe_q;
      len_d     = len_q;
      status_d  = status_q;
      wc_d      = wc_q;
      ec_d      = ec_q;
      ptr_load  = 1'b0;
      src_inc   = 1'b0;
      dst_inc   = 1'b0;
      src_rd_en = 1'b0;
      dst_wr_en = 1'b0;
      cont      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               mode_d   = mode;
               soe_d    = stop_on_err;
               len_d    = len;
               ptr_load = 1'b1;
               status_d = ST_NONE;
               wc_d     = '0;
               ec_d     = '0;
               if (mode == MODE_LEN && len == '0) begin
                  status_d = ST_LEN;
                  state_d  = S_DONE;
               end else begin
                  state_d  = S_RD;
               end
            end
         end
         S_RD: begin
            if (abort) begin
               status_d = ST_ABORT;
               state_d  = S_DONE;
            end else begin
               src_rd_en = 1'b1;
               state_d   = S_CHK;
            end
         end
         S_CHK: begin
            if (abort) begin
               status_d = ST_ABORT;
               state_d  = S_DONE;
            end else if (par_err && soe_q) begin
               ec_d     = ec_inc;
               status_d = ST_ERR;
               state_d  = S_DONE;
            end else if (par_err) begin
               ec_d = ec_inc;
               cont = 1'b1;
            end else if (mode_q == MODE_SENT && src_rd_data == SENTINEL) begin
               status_d = ST_SENT;
               state_d  = S_DONE;
            end else if (dst_exh) begin
               status_d = ST_FULL;
               state_d  = S_DONE;
            end else begin
               dst_wr_en = 1'b1;
               dst_inc   = 1'b1;
               wc_d      = wc_q + (ADDR_W + 1)'(1);
               cont      = 1'b1;
            end
            // Word consumed without terminating: decide whether to read another.
            if (cont) begin
               state_d = S_DONE;
               if (mode_q == MODE_LEN && wc_d == len_q) begin
                  status_d = ST_LEN;
               end else if (src_at_last) begin
                  status_d = ST_SRC_END;
               end else begin
                  src_inc = 1'b1;
                  state_d = S_RD;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Control state, latched run configuration and reported results.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         mode_q   <= MODE_SENT;
         soe_q    <= 1'b0;
         len_q    <= '0;
         status_q <= ST_NONE;
         wc_q     <= '0;
         ec_q     <= '0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         soe_q    <= soe_d;
         len_q    <= len_d;
         status_q <= status_d;
         wc_q     <= wc_d;
         ec_q     <= ec_d;
      end
   end

   assign src_addr    = src_ptr;
   assign dst_addr    = dst_ptr;
   assign dst_wr_data = dst_wr_en ? src_rd_data : '0;
   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_DONE);
   assign status      = status_q;
   assign word_cnt    = wc_q;
   assign err_cnt     = ec_q;

endmodule

// File: tb/tb_copy_dma.sv
// Directed bench for copy_dma with a source RAM model and a write scoreboard.
module tb_copy_dma;

   localparam int ADDR_W = 12;
   localparam int WIDTH  = 16;
   localparam int ERR_W  = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0, abort = 1'b0, mode = 1'b0, stop_on_err = 1'b0;
   logic [ADDR_W-1:0] src_start = '0, dst_start = '0;
   logic [ADDR_W:0]   len = '0;
   logic              src_rd_en, dst_wr_en, busy, done;
   logic [ADDR_W-1:0] src_addr, dst_addr;
   logic [WIDTH-1:0]  src_rd_data = '0, dst_wr_data;
   logic              src_rd_par = 1'b0;
   logic [2:0]        status;
   logic [ADDR_W:0]   word_cnt;
   logic [ERR_W-1:0]  err_cnt;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [WIDTH-1:0]  data;
   } wr_t;

   wr_t              sb[$];
   logic [WIDTH-1:0] src_mem [0:(1<<ADDR_W)-1];
   logic             src_bad [0:(1<<ADDR_W)-1];
   logic             dst_written [0:(1<<ADDR_W)-1];
   int               checks = 0;
   int               errors = 0;
   int               rd_count = 0;
   int               rd_mark;

   copy_dma #(.ADDR_W(ADDR_W), .WIDTH(WIDTH), .ERR_W(ERR_W)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
      .stop_on_err(stop_on_err), .src_start(src_start), .dst_start(dst_start),
      .len(len), .src_rd_en(src_rd_en), .src_addr(src_addr),
      .src_rd_data(src_rd_data), .src_rd_par(src_rd_par), .dst_wr_en(dst_wr_en),
      .dst_addr(dst_addr), .dst_wr_data(dst_wr_data), .busy(busy), .done(done),
      .status(status), .word_cnt(word_cnt), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Synchronous source RAM: data and parity valid the cycle after the strobe.
   always @(posedge clk) begin
      if (src_rd_en) begin
         src_rd_data <= src_mem[src_addr];
         src_rd_par  <= (^src_mem[src_addr]) ^ src_bad[src_addr];
      end
      if (dst_wr_en) dst_written[dst_addr] <= 1'b1;
   end

   // Write monitor: every destination strobe must match the next expected write.
   always @(negedge clk) begin
      if (dst_wr_en) begin
         if (sb.size() == 0) begin
            check("extra_wr", 32'(dst_wr_en), 32'd0);
         end else begin
            wr_t e;
            e = sb.pop_front();
            check("wr_addr", 32'(dst_addr), 32'(e.addr));
            check("wr_data", 32'(dst_wr_data), 32'(e.data));
         end
      end
      if (src_rd_en) rd_count++;
   end

   task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      sb.push_back(e);
   endtask

   // Present a configuration with start for one cycle; returns at cycle 1's negedge.
   task automatic kick(input logic m, input logic soe, input logic [ADDR_W-1:0] sa,
                       input logic [ADDR_W-1:0] da, input logic [ADDR_W:0] ln);
      @(negedge clk);
      mode = m; stop_on_err = soe; src_start = sa; dst_start = da; len = ln;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic finish_run(input string tag, input logic [2:0] st, input int wc, input int ec);
      for (int i = 0; i < 400; i++) begin
         if (done) break;
         @(negedge clk);
      end
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
      check({tag, "_status"}, 32'(status), 32'(st));
      check({tag, "_word_cnt"}, 32'(word_cnt), 32'(wc));
      check({tag, "_err_cnt"}, 32'(err_cnt), 32'(ec));
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      check({tag, "_idle"}, 32'(busy), 32'd0);
      check({tag, "_status_hold"}, 32'(status), 32'(st));
      check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < (1 << ADDR_W); i++) begin
         src_mem[i]     = 16'h0000;
         src_bad[i]     = 1'b0;
         dst_written[i] = 1'b0;
      end
      src_mem[0] = 16'h1234; src_mem[1] = 16'hABCD; src_mem[2] = 16'h0ACE; src_mem[3] = 16'hFFFF;
      src_mem[10] = 16'h55AA; src_bad[10] = 1'b1; src_mem[11] = 16'h0001; src_mem[12] = 16'hFFFF;
      src_mem[20] = 16'h1111; src_mem[21] = 16'h2222; src_mem[22] = 16'h3333; src_mem[23] = 16'hFFFF;
      src_mem[4093] = 16'hA001; src_mem[4094] = 16'hA002; src_mem[4095] = 16'hA003;
      src_mem[30] = 16'h0042; src_mem[31] = 16'hFFFF; src_mem[32] = 16'h0043;
      for (int i = 0; i < 5; i++) src_mem[40 + i] = 16'(16'h0101 * (i + 1));
      for (int i = 0; i < 8; i++) src_mem[50 + i] = 16'(16'h0200 + i);

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_status", 32'(status), 32'd0);
      check("rst_word_cnt", 32'(word_cnt), 32'd0);
      check("rst_err_cnt", 32'(err_cnt), 32'd0);
      check("rst_rd_en", 32'(src_rd_en), 32'd0);
      check("rst_wr_en", 32'(dst_wr_en), 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // Sentinel mode with first-read and first-write latency.
      expect_wr(12'd100, 16'h1234); expect_wr(12'd101, 16'hABCD); expect_wr(12'd102, 16'h0ACE);
      kick(1'b0, 1'b0, 12'd0, 12'd100, '0);
      check("sent_c1_rd_en", 32'(src_rd_en), 32'd1);
      check("sent_c1_addr", 32'(src_addr), 32'd0);
      check("sent_c1_busy", 32'(busy), 32'd1);
      @(negedge clk);
      check("sent_c2_wr_en", 32'(dst_wr_en), 32'd1);
      finish_run("sent", 3'd1, 3, 0);
      check("sent_103_untouched", 32'(dst_written[103]), 32'd0);

      // Parity error, drop and continue.
      expect_wr(12'd200, 16'h0001);
      kick(1'b0, 1'b0, 12'd10, 12'd200, '0);
      finish_run("par_drop", 3'd1, 1, 1);

      // Parity error, stop.
      rd_mark = rd_count;
      kick(1'b0, 1'b1, 12'd10, 12'd210, '0);
      finish_run("par_stop", 3'd5, 0, 1);
      check("par_stop_reads", 32'(rd_count - rd_mark), 32'd1);

      // Destination full, no wrap.
      expect_wr(12'd4094, 16'h1111); expect_wr(12'd4095, 16'h2222);
      kick(1'b0, 1'b0, 12'd20, 12'd4094, '0);
      finish_run("full", 3'd4, 2, 0);
      check("full_no_wrap", 32'(dst_written[0]), 32'd0);

      // Source end.
      expect_wr(12'd300, 16'hA001); expect_wr(12'd301, 16'hA002); expect_wr(12'd302, 16'hA003);
      kick(1'b0, 1'b0, 12'd4093, 12'd300, '0);
      finish_run("src_end", 3'd3, 3, 0);

      // Length mode copies the sentinel value as data.
      expect_wr(12'd400, 16'h0042); expect_wr(12'd401, 16'hFFFF);
      kick(1'b1, 1'b0, 12'd30, 12'd400, 13'd2);
      finish_run("len2", 3'd2, 2, 0);

      // Length zero: done in cycle 1, no strobes.
      rd_mark = rd_count;
      kick(1'b1, 1'b0, 12'd30, 12'd410, 13'd0);
      check("len0_c1_done", 32'(done), 32'd1);
      check("len0_c1_rd_en", 32'(src_rd_en), 32'd0);
      finish_run("len0", 3'd2, 0, 0);
      check("len0_reads", 32'(rd_count - rd_mark), 32'd0);

      // Abort during the third CHK (cycle 6).
      expect_wr(12'd500, 16'h0101); expect_wr(12'd501, 16'h0202);
      kick(1'b0, 1'b0, 12'd40, 12'd500, '0);
      repeat (4) @(negedge clk);
      @(posedge clk);
      #1 abort = 1'b1;
      @(negedge clk);
      check("abort_no_wr", 32'(dst_wr_en), 32'd0);
      finish_run("abort", 3'd6, 2, 0);
      abort = 1'b0;

      // Asynchronous reset mid-run.
      expect_wr(12'd600, 16'h0200); expect_wr(12'd601, 16'h0201);
      kick(1'b0, 1'b0, 12'd50, 12'd600, '0);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("mid_rst_rd_en", 32'(src_rd_en), 32'd0);
      check("mid_rst_wr_en", 32'(dst_wr_en), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_word_cnt", 32'(word_cnt), 32'd0);
      check("mid_rst_status", 32'(status), 32'd0);
      rd_mark = rd_count;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      check("post_rst_reads", 32'(rd_count - rd_mark), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_sb_empty", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
